// File: rtl/branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit_if
// Brief    : Decode-side request and fetch-side result channels of branch_unit.
//            Carries req_pred_taken only when BRANCH_PREDICT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int OFF_W  = 8,
    parameter int NCNT   = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [3:0]               req_cond;
    logic [ADDR_W-1:0]        req_pc;
    logic [OFF_W-1:0]         req_off;
    logic [$clog2(NCNT)-1:0]  req_cnt_sel;
`ifdef BRANCH_PREDICT_EN
    logic                     req_pred_taken;
`endif
    logic                     res_valid;
    logic                     res_ready;
    logic                     res_taken;
    logic [ADDR_W-1:0]        res_target;
    logic                     res_flush;

    modport slave (
`ifdef BRANCH_PREDICT_EN
        input  req_pred_taken,
`endif
        input  req_valid, req_cond, req_pc, req_off, req_cnt_sel, res_ready,
        output req_ready, res_valid, res_taken, res_target, res_flush
    );

    modport master (
`ifdef BRANCH_PREDICT_EN
        output req_pred_taken,
`endif
        output req_valid, req_cond, req_pc, req_off, req_cnt_sel, res_ready,
        input  req_ready, res_valid, res_taken, res_target, res_flush
    );
endinterface
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Brief    : Registered branch resolution stage: flag register, condition
//            evaluation, DBNZ loop counters, target generation and flush.
//            Optional macro BRANCH_PREDICT_EN adds prediction check/counter.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit #(
    parameter int ADDR_W = 16,
    parameter int OFF_W  = 8,
    parameter int NCNT   = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic [3:0]              flags_in,
    input  wire logic                    flags_we,
    output logic      [3:0]              flags_q,
    input  wire logic                    cnt_we,
    input  wire logic [$clog2(NCNT)-1:0] cnt_wsel,
    input  wire logic [CNT_W-1:0]        cnt_wdata,
`ifdef BRANCH_PREDICT_EN
    output logic      [15:0]             mispredict_cnt,
`endif
    branch_unit_if.slave                 bus
);
    localparam int         c_SEL_W     = $clog2(NCNT);
    localparam logic [3:0] c_COND_DBNZ = 4'd15;

    logic [3:0]        r_flags;
    logic [CNT_W-1:0]  r_cnt [NCNT];
    logic              r_res_valid;
    logic              r_res_taken;
    logic [ADDR_W-1:0] r_res_target;
    logic              r_res_pred;

    logic [3:0]        w_flags;
    logic              w_n, w_z, w_v, w_c;
    logic              w_accept;
    logic              w_is_dbnz;
    logic [CNT_W-1:0]  w_cnt_dec;
    logic              w_taken;
    logic [ADDR_W-1:0] w_off_ext;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_target;

    assign bus.req_ready = ~r_res_valid | bus.res_ready;
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_is_dbnz     = (bus.req_cond == c_COND_DBNZ);

    // A flag write in the accepting cycle is bypassed into the evaluation.
    assign w_flags = flags_we ? flags_in : r_flags;
    assign w_c     = w_flags[0];
    assign w_v     = w_flags[1];
    assign w_z     = w_flags[2];
    assign w_n     = w_flags[3];

    assign w_cnt_dec = r_cnt[bus.req_cnt_sel] - CNT_W'(1);

    always_comb begin
        w_taken = 1'b0;
        case (bus.req_cond)
            4'd0:    w_taken = w_z;
            4'd1:    w_taken = ~w_z;
            4'd2:    w_taken = w_n ^ w_v;
            4'd3:    w_taken = ~(w_n ^ w_v);
            4'd4:    w_taken = w_c;
            4'd5:    w_taken = ~w_c;
            4'd6:    w_taken = w_v;
            4'd7:    w_taken = ~w_v;
            4'd8:    w_taken = w_n;
            4'd9:    w_taken = ~w_n;
            4'd10:   w_taken = ~w_z & ~(w_n ^ w_v);
            4'd11:   w_taken = w_z | (w_n ^ w_v);
            4'd12:   w_taken = ~w_c & ~w_z;
            4'd13:   w_taken = w_c | w_z;
            4'd14:   w_taken = 1'b1;
            default: w_taken = (w_cnt_dec != '0);
        endcase
    end

    assign w_off_ext = ADDR_W'($signed(bus.req_off));
    assign w_pc_next = bus.req_pc + ADDR_W'(1);
    assign w_target  = w_taken ? (w_pc_next + w_off_ext) : w_pc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (flags_we) begin
            r_flags <= flags_in;
        end
    end

    // A software write to the counter being decremented takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (cnt_we && (cnt_wsel == c_SEL_W'(i))) begin
                    r_cnt[i] <= cnt_wdata;
                end else if (w_accept && w_is_dbnz && (bus.req_cnt_sel == c_SEL_W'(i))) begin
                    r_cnt[i] <= w_cnt_dec;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_valid  <= 1'b0;
            r_res_taken  <= 1'b0;
            r_res_target <= '0;
            r_res_pred   <= 1'b0;
        end else if (w_accept) begin
            r_res_valid  <= 1'b1;
            r_res_taken  <= w_taken;
            r_res_target <= w_target;
`ifdef BRANCH_PREDICT_EN
            r_res_pred   <= bus.req_pred_taken;
`else
            r_res_pred   <= 1'b0;
`endif
        end else if (bus.res_ready) begin
            r_res_valid  <= 1'b0;
        end
    end

    assign flags_q        = r_flags;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_taken  = r_res_taken;
    assign bus.res_target = r_res_target;

`ifdef BRANCH_PREDICT_EN
    logic [15:0] r_mis_cnt;

    // Count a mispredict once, when its result is consumed; saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mis_cnt <= '0;
        end else if (r_res_valid && bus.res_ready && (r_res_taken != r_res_pred)
                     && (r_mis_cnt != 16'hFFFF)) begin
            r_mis_cnt <= r_mis_cnt + 16'd1;
        end
    end

    assign mispredict_cnt = r_mis_cnt;
    assign bus.res_flush  = r_res_valid & (r_res_taken != r_res_pred);
`else
    assign bus.res_flush  = r_res_valid & r_res_taken;
`endif
endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_unit
// Brief    : Directed and randomized bench for branch_unit against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_unit;
    localparam int ADDR_W = 16;
    localparam int OFF_W  = 8;
    localparam int NCNT   = 4;
    localparam int CNT_W  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  flags_in;
    logic        flags_we;
    logic [3:0]  flags_q;
    logic        cnt_we;
    logic [1:0]  cnt_wsel;
    logic [7:0]  cnt_wdata;
`ifdef BRANCH_PREDICT_EN
    logic [15:0] mispredict_cnt;
`endif

    branch_unit_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .NCNT(NCNT)) bus ();

    branch_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .NCNT(NCNT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flags_in       (flags_in),
        .flags_we       (flags_we),
        .flags_q        (flags_q),
        .cnt_we         (cnt_we),
        .cnt_wsel       (cnt_wsel),
        .cnt_wdata      (cnt_wdata),
`ifdef BRANCH_PREDICT_EN
        .mispredict_cnt (mispredict_cnt),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] m_flags;
    int         m_cnt [NCNT];
    bit         m_valid, m_taken, m_pred;
    int         m_target;
    int         m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_true(input logic [3:0] f, input int cond, input int cnt_after);
        bit n, z, v, c;
        c = f[0]; v = f[1]; z = f[2]; n = f[3];
        case (cond)
            0:  return z;
            1:  return !z;
            2:  return n != v;
            3:  return n == v;
            4:  return c;
            5:  return !c;
            6:  return v;
            7:  return !v;
            8:  return n;
            9:  return !n;
            10: return !z && (n == v);
            11: return z || (n != v);
            12: return !c && !z;
            13: return c || z;
            14: return 1'b1;
            default: return cnt_after != 0;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 4'h0;
        for (int i = 0; i < NCNT; i++) m_cnt[i] = 0;
        m_valid = 0; m_taken = 0; m_pred = 0; m_target = 0; m_mis = 0;
    endtask

    task automatic check_outputs();
        chk("res_valid", bus.res_valid, m_valid);
        if (m_valid) begin
            chk("res_taken", bus.res_taken, m_taken);
            chk("res_target", bus.res_target, m_target);
        end
`ifdef BRANCH_PREDICT_EN
        chk("res_flush", bus.res_flush, m_valid && (m_taken != m_pred));
        chk("mispredict_cnt", mispredict_cnt, m_mis);
`else
        chk("res_flush", bus.res_flush, m_valid && m_taken);
`endif
        chk("flags_q", flags_q, m_flags);
    endtask

    // Called at a negedge with inputs already driven; advances one clock.
    task automatic step();
        bit rdy, acc, tk, pred;
        logic [3:0] f;
        int cond, sel, after, soff, pc, tgt;
        #1;
        rdy = !m_valid || bus.res_ready;
        chk("req_ready", bus.req_ready, rdy);
        acc   = bus.req_valid && rdy;
        f     = flags_we ? flags_in : m_flags;
        cond  = int'(bus.req_cond);
        sel   = int'(bus.req_cnt_sel);
        after = (m_cnt[sel] + 255) % 256;
        tk    = cond_true(f, cond, after);
        soff  = int'(bus.req_off);
        if (soff >= 128) soff -= 256;
        pc    = int'(bus.req_pc);
        tgt   = tk ? ((pc + 1 + soff) & 16'hFFFF) : ((pc + 1) & 16'hFFFF);
`ifdef BRANCH_PREDICT_EN
        pred  = bus.req_pred_taken;
`else
        pred  = 1'b0;
`endif
        if (m_valid && bus.res_ready && (m_taken != m_pred) && m_mis < 65535) m_mis++;
        if (cnt_we) m_cnt[cnt_wsel] = int'(cnt_wdata);
        if (acc && cond == 15 && !(cnt_we && int'(cnt_wsel) == sel)) m_cnt[sel] = after;
        if (flags_we) m_flags = flags_in;
        if (acc) begin
            m_valid = 1; m_taken = tk; m_target = tgt; m_pred = pred;
        end else if (bus.res_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_req(input bit v, input int cond, input int pc, input int off, input int sel);
        bus.req_valid   = v;
        bus.req_cond    = 4'(cond);
        bus.req_pc      = 16'(pc);
        bus.req_off     = 8'(off);
        bus.req_cnt_sel = 2'(sel);
    endtask

    task automatic drive_side(input bit fwe, input int fin, input bit cwe, input int csel, input int cdata);
        flags_we  = fwe;
        flags_in  = 4'(fin);
        cnt_we    = cwe;
        cnt_wsel  = 2'(csel);
        cnt_wdata = 8'(cdata);
    endtask

    initial begin
        logic [15:0] held_target;
        reset = 1'b1;
        drive_side(0, 0, 0, 0, 0);
        drive_req(0, 0, 0, 0, 0);
        bus.res_ready = 1'b1;
`ifdef BRANCH_PREDICT_EN
        bus.req_pred_taken = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_taken", bus.res_taken, 0);
        chk("rst_target", bus.res_target, 0);
        chk("rst_flush", bus.res_flush, 0);
        chk("rst_flags", flags_q, 0);
        reset = 1'b0;

        // LT/GE with N=1, V=0
        drive_side(1, 4'b1000, 0, 0, 0); step();
        drive_side(0, 0, 0, 0, 0);
        drive_req(1, 2, 16'h0100, 8'hFE, 0); step();
        chk("lt_taken", bus.res_taken, 1);
        chk("lt_target", bus.res_target, 16'h00FF);
        chk("lt_flush", bus.res_flush, 1);
        drive_req(1, 3, 16'h0100, 8'hFE, 0); step();
        chk("ge_taken", bus.res_taken, 0);
        chk("ge_target", bus.res_target, 16'h0101);

        // Flag bypass
        drive_req(0, 0, 0, 0, 0);
        drive_side(1, 0, 0, 0, 0); step();
        drive_side(1, 4'b0100, 0, 0, 0);
        drive_req(1, 0, 16'h0010, 8'h20, 0); step();
        chk("bypass_taken", bus.res_taken, 1);
        chk("bypass_flags", flags_q, 4'h4);

        // DBNZ on counter 2
        drive_req(0, 0, 0, 0, 0);
        drive_side(0, 0, 1, 2, 3); step();
        drive_side(0, 0, 0, 0, 0);
        drive_req(1, 15, 16'h0040, 8'hF0, 2); step();
        chk("dbnz1_taken", bus.res_taken, 1);
        step();
        chk("dbnz2_taken", bus.res_taken, 1);
        step();
        chk("dbnz3_taken", bus.res_taken, 0);
        chk("dbnz3_target", bus.res_target, 16'h0041);
        step();
        chk("dbnz4_taken", bus.res_taken, 1);
        chk("dbnz4_target", bus.res_target, 16'h0031);
        // Write collides with decrement: write wins, taken from old value 0xFF
        drive_side(0, 0, 1, 2, 5); step();
        chk("coll_taken", bus.res_taken, 1);
        drive_side(0, 0, 0, 0, 0); step();

        // Backpressure stall
        drive_req(1, 14, 16'h0300, 8'h04, 0); step();
        held_target = bus.res_target;
        bus.res_ready = 1'b0;
        drive_req(1, 14, 16'h0200, 8'h10, 0);
        repeat (3) step();
        chk("stall_target", bus.res_target, held_target);
        bus.res_ready = 1'b1; step();
        chk("release_target", bus.res_target, 16'h0211);
        drive_req(0, 0, 0, 0, 0); step();
        chk("drain_valid", bus.res_valid, 0);

        // PC wrap, then reset while holding a result
        drive_req(1, 14, 16'hFFFF, 8'h01, 0); step();
        chk("wrap_target", bus.res_target, 16'h0001);
        drive_req(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("midrst_valid", bus.res_valid, 0);
        chk("midrst_flush", bus.res_flush, 0);
        chk("midrst_flags", flags_q, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_req(1, 15, 16'h0500, 8'h08, 2); step();
        chk("midrst_cnt_wrap", bus.res_taken, 1);

`ifdef BRANCH_PREDICT_EN
        drive_req(0, 0, 0, 0, 0);
        drive_side(1, 4'b0100, 0, 0, 0); step();
        drive_side(0, 0, 0, 0, 0);
        bus.req_pred_taken = 1'b1;
        drive_req(1, 1, 16'h0600, 8'h10, 0); step();
        chk("pred_ne_flush", bus.res_flush, 1);
        chk("pred_ne_target", bus.res_target, 16'h0601);
        drive_req(1, 0, 16'h0700, 8'h10, 0); step();
        chk("pred_mis_cnt", mispredict_cnt, 1);
        chk("pred_eq_flush", bus.res_flush, 0);
`endif

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive_side($urandom_range(0, 1), int'($urandom_range(0, 15)),
                       ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
            drive_req($urandom_range(0, 3) != 0,
                      ($urandom_range(0, 2) == 0) ? 15 : int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 3)));
            bus.res_ready = ($urandom_range(0, 3) != 0);
`ifdef BRANCH_PREDICT_EN
            bus.req_pred_taken = 1'($urandom_range(0, 1));
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
